// File: rtl/crc16_pkg.sv
// crc16_pkg: shared types and helpers for the byte-serial CRC-16 engine.
//   crc_state_e  : engine FSM states (IDLE, SHIFT, DONE)
//   CRC16_MODBUS_POLY / CRC16_MODBUS_INIT : CRC-16/MODBUS defaults
//   crc_bit_step : one reflected (LSB-first) CRC shift step
package crc16_pkg;

  localparam int unsigned CRC_W  = 16;
  localparam int unsigned BYTE_W = 8;

  localparam logic [CRC_W-1:0] CRC16_MODBUS_POLY = 16'hA001;
  localparam logic [CRC_W-1:0] CRC16_MODBUS_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } crc_state_e;

  // One reflected step: shift right, fold the polynomial in when a 1 drops out.
  function automatic logic [CRC_W-1:0] crc_bit_step(input logic [CRC_W-1:0] crc,
                                                     input logic [CRC_W-1:0] poly);
    return crc[0] ? ((crc >> 1) ^ poly) : (crc >> 1);
  endfunction

endpackage

// File: rtl/crc16_step.sv
// crc16_step: combinational BITS-deep unrolled chain of crc_bit_step.
// Ports:
//   crc        in  16  current CRC register value
//   crc_next_c out 16  CRC after BITS reflected shift steps (combinational)
module crc16_step
  import crc16_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = CRC16_MODBUS_POLY,
  parameter int unsigned      BITS = 1
) (
  input  logic [CRC_W-1:0] crc,
  output logic [CRC_W-1:0] crc_next_c
);

  always_comb begin
    crc_next_c = crc;
    for (int unsigned i = 0; i < BITS; i++) begin
      crc_next_c = crc_bit_step(crc_next_c, POLY);
    end
  end

endmodule

// File: rtl/crc16_stream.sv
// crc16_stream: byte-serial reflected CRC-16 engine with valid/ready input,
// frame start/end markers, saturating per-frame byte counter and an
// end-of-frame result strobe. Defaults give CRC-16/MODBUS.
// Optional feature macro: CRC16_CHECK_EN builds the zero-residue receive
// check driving crc_ok; without it crc_ok is tied low.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear           abort frame, reload INIT, zero byte_cnt
//   in_valid/in_ready/in_data  byte handshake (in_ready is combinational)
//   sof, eof        first / last byte of frame, qualify in_data
//   crc_out         current CRC register, [7:0] transmitted first
//   crc_valid       one-cycle strobe, crc_out is the frame result
//   crc_ok          residue == 0 check, valid with crc_valid
//   busy            engine not idle
//   byte_cnt        bytes accepted in current frame (saturating)
module crc16_stream
  import crc16_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY         = CRC16_MODBUS_POLY,
  parameter logic [CRC_W-1:0] INIT         = CRC16_MODBUS_INIT,
  parameter int unsigned      BITS_PER_CYC = 1,
  parameter int unsigned      CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              sof,
  input  logic              eof,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_valid,
  output logic              crc_ok,
  output logic              busy,
  output logic [CNT_W-1:0]  byte_cnt
);

  localparam bit          BPC_LEGAL = (BITS_PER_CYC == 1) || (BITS_PER_CYC == 2) ||
                                      (BITS_PER_CYC == 4) || (BITS_PER_CYC == 8);
  localparam int unsigned N_CYC     = BPC_LEGAL ? (BYTE_W / BITS_PER_CYC) : 1;
  localparam int unsigned SC_W      = 3;

  if (!BPC_LEGAL) begin : g_bad_bpc
    $error("crc16_stream: BITS_PER_CYC must be 1, 2, 4 or 8");
  end

  crc_state_e       state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d, crc_step_c;
  logic [SC_W-1:0]  shift_cnt_q, shift_cnt_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic             eof_q, eof_d;
  logic             crc_valid_q, crc_valid_d;
  logic             busy_q, busy_d;
  logic             accept_c;
  logic             last_shift_c;

  crc16_step #(
    .POLY (POLY),
    .BITS (BITS_PER_CYC)
  ) u_step (
    .crc        (crc_q),
    .crc_next_c (crc_step_c)
  );

  // Ready is gated combinationally so a same-cycle clear or reset never accepts.
  assign in_ready     = (state_q == IDLE) && !clear && !rst;
  assign accept_c     = in_valid && in_ready;
  assign last_shift_c = (shift_cnt_q == SC_W'(N_CYC - 1));

`ifdef CRC16_CHECK_EN
  logic crc_ok_q, crc_ok_d;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    shift_cnt_d = shift_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    eof_d       = eof_q;
    crc_valid_d = 1'b0;
`ifdef CRC16_CHECK_EN
    crc_ok_d    = 1'b0;
`endif
    if (clear) begin
      state_d     = IDLE;
      crc_d       = INIT;
      shift_cnt_d = '0;
      byte_cnt_d  = '0;
      eof_d       = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            crc_d       = (sof ? INIT : crc_q) ^ {8'h00, in_data};
            eof_d       = eof;
            shift_cnt_d = '0;
            if (sof)              byte_cnt_d = CNT_W'(1);
            else if (!(&byte_cnt_q)) byte_cnt_d = byte_cnt_q + CNT_W'(1);
            state_d     = SHIFT;
          end
        end
        SHIFT: begin
          crc_d       = crc_step_c;
          shift_cnt_d = shift_cnt_q + SC_W'(1);
          if (last_shift_c) begin
            state_d     = eof_q ? DONE : IDLE;
            crc_valid_d = eof_q;
`ifdef CRC16_CHECK_EN
            // Residue of frame plus appended CRC is zero when intact.
            crc_ok_d    = eof_q && (crc_step_c == '0);
`endif
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      crc_q       <= INIT;
      shift_cnt_q <= '0;
      byte_cnt_q  <= '0;
      eof_q       <= 1'b0;
      crc_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef CRC16_CHECK_EN
      crc_ok_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      shift_cnt_q <= shift_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      eof_q       <= eof_d;
      crc_valid_q <= crc_valid_d;
      busy_q      <= busy_d;
`ifdef CRC16_CHECK_EN
      crc_ok_q    <= crc_ok_d;
`endif
    end
  end

  assign crc_out   = crc_q;
  assign crc_valid = crc_valid_q;
  assign busy      = busy_q;
  assign byte_cnt  = byte_cnt_q;
`ifdef CRC16_CHECK_EN
  assign crc_ok    = crc_ok_q;
`else
  assign crc_ok    = 1'b0;
`endif

endmodule

// File: tb/tb_crc16_stream.sv
// tb_crc16_stream: drives three engines (BITS_PER_CYC = 1, 4, 8) with directed
// and random frames and compares against a byte-level CRC-16/MODBUS model.
module tb_crc16_stream;

  localparam int unsigned NI = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear     [NI];
  logic       in_valid  [NI];
  logic       in_ready  [NI];
  logic [7:0] in_data   [NI];
  logic       sof       [NI];
  logic       eof       [NI];
  logic [15:0] crc_out  [NI];
  logic       crc_valid [NI];
  logic       crc_ok    [NI];
  logic       busy      [NI];
  logic [7:0] byte_cnt  [NI];

  int n_tests = 0;
  int n_fail  = 0;
  int vcount [NI] = '{0, 0, 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned BPC = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
    crc16_stream #(.BITS_PER_CYC(BPC)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .sof       (sof[g]),
      .eof       (eof[g]),
      .crc_out   (crc_out[g]),
      .crc_valid (crc_valid[g]),
      .crc_ok    (crc_ok[g]),
      .busy      (busy[g]),
      .byte_cnt  (byte_cnt[g])
    );
  end

  // Count result strobes per engine (sees the value held through the cycle just ended).
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) if (crc_valid[k]) vcount[k] <= vcount[k] + 1;
  end

  function automatic int ncyc(input int k);
    return (k == 0) ? 8 : ((k == 1) ? 2 : 1);
  endfunction

  // CRC-16/MODBUS reference: reflected, init FFFF, poly A001, no final xor.
  function automatic logic [15:0] model_crc(input logic [7:0] q[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (q[i]) begin
      c = c ^ {8'h00, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic exp_ok(input logic [15:0] c);
`ifdef CRC16_CHECK_EN
    return (c == 16'h0000);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input int k, input logic [7:0] d, input logic s, input logic e);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready[k] && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60) check("ready_timeout", 32'(in_ready[k]), 32'd1);
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    sof[k]      = s;
    eof[k]      = e;
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    sof[k]      = 1'b0;
    eof[k]      = 1'b0;
    in_data[k]  = 8'h00;
  endtask

  // Cycles after the accept edge until in_ready (sel=0) or crc_valid (sel=1) is seen.
  task automatic wait_for(input int k, input bit sel, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sel ? crc_valid[k] : in_ready[k]) && n < 40);
  endtask

  task automatic send_frame(input int k, input logic [7:0] q[$], input logic [15:0] exp_crc,
                            input string tag);
    int n, v0, len;
    v0  = vcount[k];
    len = q.size();
    for (int i = 0; i < len; i++) begin
      send_byte(k, q[i], i == 0, i == len - 1);
      if (i != len - 1) begin
        wait_for(k, 1'b0, n);
        if (i < 3) check({tag, "_gap"}, 32'(n), 32'(ncyc(k) + 1));
      end else begin
        wait_for(k, 1'b1, n);
        check({tag, "_valid_lat"}, 32'(n), 32'(ncyc(k) + 1));
        check({tag, "_crc"}, 32'(crc_out[k]), 32'(exp_crc));
        check({tag, "_cnt"}, 32'(byte_cnt[k]), 32'((len > 255) ? 255 : len));
        check({tag, "_ok"}, 32'(crc_ok[k]), 32'(exp_ok(exp_crc)));
      end
    end
    @(negedge clk);
    check({tag, "_valid_once"}, 32'(crc_valid[k]), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready[k]), 32'd1);
    check({tag, "_strobes"}, 32'(vcount[k] - v0), 32'd1);
    check({tag, "_crc_hold"}, 32'(crc_out[k]), 32'(exp_crc));
  endtask

  initial begin
    logic [7:0] q[$];
    logic [15:0] m;
    int k, v0, n;

    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      clear[i] = 1'b0; in_valid[i] = 1'b0; in_data[i] = 8'h00; sof[i] = 1'b0; eof[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) check("ready_in_rst", 32'(in_ready[i]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("rst_crc", 32'(crc_out[i]), 32'hFFFF);
      check("rst_valid", 32'(crc_valid[i]), 32'd0);
      check("rst_ok", 32'(crc_ok[i]), 32'd0);
      check("rst_busy", 32'(busy[i]), 32'd0);
      check("rst_cnt", 32'(byte_cnt[i]), 32'd0);
      check("rst_ready", 32'(in_ready[i]), 32'd1);
    end

    // MODBUS request frame, 1 bit per cycle.
    q = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
    send_frame(0, q, 16'h0A84, "modbus_bpc1");

    // Standard check string, 8 bits per cycle.
    q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send_frame(2, q, 16'h4B37, "check_bpc8");

    // Frame with its CRC appended leaves a zero residue; a corrupted byte does not.
    q = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    send_frame(0, q, 16'h0000, "residue");
    q[3] = 8'h40;
    send_frame(0, q, model_crc(q), "residue_bad");

    // Single byte frame, 4 bits per cycle.
    q = '{8'h01};
    send_frame(1, q, 16'h807E, "single_bpc4");

    // Clear during SHIFT cycle 3 of byte 2 (byte 2 marked eof).
    v0 = vcount[0];
    send_byte(0, 8'h5A, 1'b1, 1'b0);
    wait_for(0, 1'b0, n);
    send_byte(0, 8'hC3, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    @(negedge clk);
    clear[0] = 1'b1;
    #1;
    check("clr_busy_before", 32'(busy[0]), 32'd1);
    @(posedge clk);
    #1;
    clear[0] = 1'b0;
    @(negedge clk);
    check("clr_busy", 32'(busy[0]), 32'd0);
    check("clr_crc", 32'(crc_out[0]), 32'hFFFF);
    check("clr_cnt", 32'(byte_cnt[0]), 32'd0);
    check("clr_ready", 32'(in_ready[0]), 32'd1);
    repeat (12) @(negedge clk);
    check("clr_no_strobe", 32'(vcount[0] - v0), 32'd0);
    q = '{8'h11, 8'h22, 8'h33};
    send_frame(0, q, model_crc(q), "after_clear");

    // Clear and in_valid together: no accept.
    @(negedge clk);
    clear[1] = 1'b1; in_valid[1] = 1'b1; in_data[1] = 8'hAA; sof[1] = 1'b1;
    #1;
    check("clr_valid_ready", 32'(in_ready[1]), 32'd0);
    @(posedge clk);
    #1;
    clear[1] = 1'b0; in_valid[1] = 1'b0; sof[1] = 1'b0;
    @(negedge clk);
    check("clr_valid_cnt", 32'(byte_cnt[1]), 32'd0);
    check("clr_valid_busy", 32'(busy[1]), 32'd0);

    // Reset mid-SHIFT.
    v0 = vcount[0];
    send_byte(0, 8'h77, 1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", 32'(in_ready[0]), 32'd0);
    check("rst_mid_busy", 32'(busy[0]), 32'd0);
    check("rst_mid_crc", 32'(crc_out[0]), 32'hFFFF);
    check("rst_mid_cnt", 32'(byte_cnt[0]), 32'd0);
    check("rst_mid_valid", 32'(crc_valid[0]), 32'd0);
    check("rst_mid_ok", 32'(crc_ok[0]), 32'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("rst_mid_no_strobe", 32'(vcount[0] - v0), 32'd0);

    // Random frames across all engines.
    for (int f = 0; f < 8; f++) begin
      k = int'($urandom_range(0, NI - 1));
      q.delete();
      for (int i = 0; i < int'($urandom_range(1, 10)); i++) q.push_back(8'($urandom));
      m = model_crc(q);
      send_frame(k, q, m, $sformatf("rand%0d_k%0d", f, k));
    end

    // Long frame saturates the byte counter.
    q.delete();
    for (int i = 0; i < 300; i++) q.push_back(8'($urandom));
    send_frame(2, q, model_crc(q), "saturate");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
